bridge_loader: RTL and testbench
================================

// Module: bridge_loader
// PURPOSE
//  Upstream byte-loader for the 528-bit bridge shift register.
//  - Accepts a valid/ready byte stream and drives the bridge's data_in/shift_en, one byte per pulse.
//  - Counts BYTES_PER_BLOCK bytes, zero-pads short (in_last) frames up to a full block.
//  - Then raises blk_valid and holds off input until the block consumer returns blk_ack.
// PARAMETERS
//  BYTES_PER_BLOCK  66     bytes per block (66 x 8 = 528 bits, bridge width); must be >= 2
//  PAD_BYTE         8'h00  value shifted in to fill a short frame
//  CNT_W            7      byte_cnt width; 2**CNT_W > BYTES_PER_BLOCK
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  rst         in   1      synchronous reset, active-high
//  in_data     in   8      upstream byte
//  in_valid    in   1      in_data valid
//  in_last     in   1      in_data is final byte of frame (qualified by in_valid)
//  in_ready    out  1      loader can accept; byte taken when in_valid && in_ready
//  data_out    out  8      to bridge data_in
//  shift_en    out  1      to bridge shift_en; one-cycle pulse per byte
//  blk_valid   out  1      bridge holds a complete block
//  blk_ack     in   1      consumer has taken block (honoured only while blk_valid)
//  blk_padded  out  1      current block contains pad bytes
//  byte_cnt    out  CNT_W  bytes shifted into current block
// BEHAVIOUR
//  Reset:
//   - rst high at a clk edge -> state IDLE.
//   - shift_en, data_out, blk_valid, blk_padded, byte_cnt all 0.
//   - in_ready is 0 while rst is high.
//   - Reset mid-block abandons the partial block; the bridge contents are not cleared here.
//  Outputs:
//   - All outputs are registered except in_ready.
//   - in_ready = !rst && (state==IDLE || state==LOAD).
//  Accept latency:
//   - A byte accepted at edge k appears as data_out with shift_en=1 for the cycle after edge k.
//   - byte_cnt increments with each shift_en pulse.
//  FSM states: IDLE, LOAD, PAD, SETTLE, FULL.
//   - IDLE:
//     - accept without last -> LOAD.
//     - accept with last -> PAD.
//   - LOAD:
//     - accept making count == BYTES_PER_BLOCK -> SETTLE; this holds even if in_last is set, and blk_padded stays 0.
//     - accept with in_last and count < N -> PAD.
//     - no accept -> stay; no shift_en.
//   - PAD:
//     - in_ready=0.
//     - Each cycle: shift_en=1, data_out=PAD_BYTE, blk_padded=1.
//     - When count reaches N -> SETTLE.
//   - SETTLE:
//     - Exactly one cycle, no shift_en, lets the bridge register the last byte.
//     - -> FULL with blk_valid=1.
//   - FULL:
//     - blk_valid=1, in_ready=0.
//     - blk_ack -> IDLE: next cycle blk_valid=0, blk_padded=0, byte_cnt=0.
//  Handshake rules:
//   - blk_ack in any other state is ignored.
//   - in_valid while in_ready=0: the byte is held upstream, never dropped or duplicated.
//   - in_last without in_valid is ignored.
//  Other:
//   - Exactly BYTES_PER_BLOCK shift_en pulses per block, never more.
//   - byte_cnt never exceeds N and never wraps.
//   - Minimum block period is N+2 cycles plus the ack wait.
// TESTING
//  1. rst=1 for 2 cycles:
//     - all outputs 0 while in reset.
//     - after release, in_ready=1.
//  2. Stream 66 bytes 0x01..0x42, in_valid held high:
//     - 66 consecutive shift_en pulses.
//     - blk_valid high 2 cycles after the last pulse.
//     - bridge data_out[7:0]=0x42 and [527:520]=0x01.
//     - blk_padded=0.
//  3. Frame of 3 bytes 0x81,0x81,0xAA with in_last on 0xAA:
//     - 63 PAD pulses of 0x00 follow.
//     - blk_padded=1.
//     - bridge = {0x81,0x81,0xAA,{504{0}}}.
//  4. In FULL, hold in_valid=1 with 0x55 for 10 cycles, then blk_ack:
//     - no shift_en while in FULL.
//     - 0x55 accepted only after return to IDLE.
//  5. blk_ack pulsed during LOAD at byte_cnt=10:
//     - ignored; block completes normally at 66.
//  6. rst asserted at byte_cnt=30, then a new 66-byte stream:
//     - byte_cnt=0 after reset.
//     - new block completes after exactly 66 pulses.

Source files
------------

// File: rtl/bridge_loader.sv
// Byte loader feeding the 528-bit bridge shift register: takes a valid/ready byte
// stream, pads short frames to a full block, then holds the block until acknowledged.
module bridge_loader #(
  parameter int          BYTES_PER_BLOCK = 66,
  parameter logic [7:0]  PAD_BYTE        = 8'h00,
  parameter int          CNT_W           = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [7:0]       data_out,
  output logic             shift_en,
  output logic             blk_valid,
  input  logic             blk_ack,
  output logic             blk_padded,
  output logic [CNT_W-1:0] byte_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    PAD    = 3'd2,
    SETTLE = 3'd3,
    FULL   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BYTES_PER_BLOCK);

  state_e           state_q, state_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             shift_en_q, shift_en_d;
  logic             blk_valid_q, blk_valid_d;
  logic             blk_padded_q, blk_padded_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;

  assign in_ready = !rst && (state_q == IDLE || state_q == LOAD);
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = byte_cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    data_out_d   = data_out_q;
    shift_en_d   = 1'b0;
    blk_valid_d  = blk_valid_q;
    blk_padded_d = blk_padded_q;
    byte_cnt_d   = byte_cnt_q;
    unique case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          shift_en_d = 1'b1;
          data_out_d = in_data;
          byte_cnt_d = cnt_inc;
          // A full count wins over in_last: the frame fits exactly, no padding.
          if (cnt_inc == FULL_CNT)  state_d = SETTLE;
          else if (in_last)         state_d = PAD;
          else                      state_d = LOAD;
        end
      end
      PAD: begin
        shift_en_d   = 1'b1;
        data_out_d   = PAD_BYTE;
        blk_padded_d = 1'b1;
        byte_cnt_d   = cnt_inc;
        if (cnt_inc == FULL_CNT) state_d = SETTLE;
      end
      SETTLE: begin
        state_d = FULL;
      end
      FULL: begin
        // blk_valid rises one cycle after entering FULL, leaving a quiet cycle
        // after the last shift so the bridge has registered it.
        if (blk_valid_q && blk_ack) begin
          state_d      = IDLE;
          blk_valid_d  = 1'b0;
          blk_padded_d = 1'b0;
          byte_cnt_d   = '0;
        end else begin
          blk_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      data_out_q   <= '0;
      shift_en_q   <= 1'b0;
      blk_valid_q  <= 1'b0;
      blk_padded_q <= 1'b0;
      byte_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      data_out_q   <= data_out_d;
      shift_en_q   <= shift_en_d;
      blk_valid_q  <= blk_valid_d;
      blk_padded_q <= blk_padded_d;
      byte_cnt_q   <= byte_cnt_d;
    end
  end

  assign data_out   = data_out_q;
  assign shift_en   = shift_en_q;
  assign blk_valid  = blk_valid_q;
  assign blk_padded = blk_padded_q;
  assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_bridge_loader.sv
// Directed bench for bridge_loader with a behavioural 528-bit bridge shift register.
module tb_bridge_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] data_out;
  logic       shift_en;
  logic       blk_valid;
  logic       blk_ack = 1'b0;
  logic       blk_padded;
  logic [6:0] byte_cnt;

  int checks = 0;
  int errors = 0;

  logic [527:0] bridge = '0;
  logic [527:0] exp_bridge;
  int pulse_cnt = 0;
  int pad_cnt = 0;
  logic ok;

  bridge_loader #(.BYTES_PER_BLOCK(66), .PAD_BYTE(8'h00), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .data_out(data_out), .shift_en(shift_en), .blk_valid(blk_valid),
    .blk_ack(blk_ack), .blk_padded(blk_padded), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  // Bridge model: shifts left by a byte on each shift_en
  always @(posedge clk) begin
    if (shift_en) begin
      bridge <= {bridge[519:0], data_out};
      pulse_cnt = pulse_cnt + 1;
      if (blk_padded && data_out == 8'h00) pad_cnt = pad_cnt + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [527:0] obs, input logic [527:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a byte and wait (bounded) until it is taken at a clock edge.
  task automatic send_byte(input logic [7:0] d, input logic last);
    int guard;
    guard = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    while (!in_ready && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) check("accept_timeout", in_ready, 1'b1);
    step();
  endtask

  task automatic do_ack(input string tag);
    blk_ack = 1'b1;
    step();
    blk_ack = 1'b0;
    check(tag, {blk_valid, blk_padded, byte_cnt}, 9'd0);
  endtask

  initial begin
    // 1. reset
    step();
    check("rst_outputs", {shift_en, data_out, blk_valid, blk_padded, byte_cnt}, '0);
    check("rst_in_ready", in_ready, 1'b0);
    step();
    check("rst_outputs2", {shift_en, data_out, blk_valid, blk_padded, byte_cnt}, '0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // 2. full 66-byte block 0x01..0x42
    pulse_cnt = 0;
    ok = 1'b1;
    exp_bridge = '0;
    for (int i = 1; i <= 66; i++) begin
      send_byte(8'(i), 1'b0);
      ok &= shift_en && (data_out == 8'(i)) && (byte_cnt == 7'(i));
      exp_bridge = {exp_bridge[519:0], 8'(i)};
    end
    in_valid = 1'b0;
    check("t2_consecutive_pulses", ok, 1'b1);
    step();
    check("t2_settle_quiet", {shift_en, blk_valid, in_ready}, 3'b000);
    step();
    check("t2_blk_valid", blk_valid, 1'b1);
    check("t2_blk_padded", blk_padded, 1'b0);
    check("t2_byte_cnt", byte_cnt, 7'd66);
    check("t2_pulse_cnt", pulse_cnt, 66);
    check("t2_bridge_lsb", bridge[7:0], 8'h42);
    check("t2_bridge_msb", bridge[527:520], 8'h01);
    check("t2_bridge", bridge, exp_bridge);

    // 4. byte held upstream while FULL, then accepted after ack (single-byte frame)
    in_data = 8'h55; in_valid = 1'b1; in_last = 1'b1;
    pulse_cnt = 0;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      ok &= !shift_en && blk_valid && !in_ready;
    end
    check("t4_hold_in_full", ok, 1'b1);
    check("t4_no_pulse_full", pulse_cnt, 0);
    do_ack("t4_ack_clear");
    check("t4_ready_after_ack", {in_ready, shift_en}, 2'b10);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    check("t4_55_accepted", {shift_en, data_out, byte_cnt}, {1'b1, 8'h55, 7'd1});
    repeat (67) step();
    check("t4_blk", {blk_valid, blk_padded, byte_cnt}, {1'b1, 1'b1, 7'd66});
    check("t4_pulse_cnt", pulse_cnt, 66);
    check("t4_bridge", bridge, {8'h55, 520'd0});
    do_ack("t4_ack2");

    // 3. short frame 0x81,0x81,0xAA -> 63 pad bytes
    pulse_cnt = 0; pad_cnt = 0;
    send_byte(8'h81, 1'b0);
    send_byte(8'h81, 1'b0);
    send_byte(8'hAA, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    check("t3_last_data", {shift_en, data_out, blk_padded, byte_cnt}, {1'b1, 8'hAA, 1'b0, 7'd3});
    step();
    check("t3_first_pad", {shift_en, data_out, blk_padded, in_ready}, {1'b1, 8'h00, 1'b1, 1'b0});
    repeat (62) step();
    check("t3_last_pad", {shift_en, byte_cnt}, {1'b1, 7'd66});
    step();
    check("t3_settle", {shift_en, blk_valid}, 2'b00);
    step();
    check("t3_blk", {blk_valid, blk_padded}, 2'b11);
    check("t3_pad_cnt", pad_cnt, 63);
    check("t3_pulse_cnt", pulse_cnt, 66);
    check("t3_bridge", bridge, {24'h8181AA, 504'd0});
    do_ack("t3_ack");

    // 5. blk_ack during LOAD is ignored
    pulse_cnt = 0;
    exp_bridge = '0;
    for (int i = 0; i < 10; i++) begin
      send_byte(8'(8'hA0 + i), 1'b0);
      exp_bridge = {exp_bridge[519:0], 8'(8'hA0 + i)};
    end
    in_valid = 1'b0;
    check("t5_cnt10", byte_cnt, 7'd10);
    blk_ack = 1'b1;
    step();
    blk_ack = 1'b0;
    check("t5_ack_ignored", {blk_valid, byte_cnt, in_ready, shift_en}, {1'b0, 7'd10, 1'b1, 1'b0});
    for (int i = 10; i < 66; i++) begin
      send_byte(8'(8'hA0 + i), 1'b0);
      exp_bridge = {exp_bridge[519:0], 8'(8'hA0 + i)};
    end
    in_valid = 1'b0;
    step();
    step();
    check("t5_blk", {blk_valid, blk_padded, byte_cnt}, {1'b1, 1'b0, 7'd66});
    check("t5_pulse_cnt", pulse_cnt, 66);
    check("t5_bridge", bridge, exp_bridge);
    do_ack("t5_ack");

    // 6. reset mid-block, then a fresh full block
    for (int i = 0; i < 30; i++) send_byte(8'hC3, 1'b0);
    in_valid = 1'b0;
    check("t6_cnt30", byte_cnt, 7'd30);
    rst = 1'b1;
    step();
    check("t6_rst_outputs", {shift_en, data_out, blk_valid, blk_padded, byte_cnt, in_ready}, '0);
    rst = 1'b0;
    #1;
    check("t6_ready", in_ready, 1'b1);
    pulse_cnt = 0;
    exp_bridge = '0;
    for (int i = 0; i < 66; i++) begin
      send_byte(8'(8'h10 + i), 1'b0);
      exp_bridge = {exp_bridge[519:0], 8'(8'h10 + i)};
    end
    in_valid = 1'b0;
    check("t6_cnt66", byte_cnt, 7'd66);
    step();
    check("t6_settle", {shift_en, blk_valid}, 2'b00);
    step();
    check("t6_blk_valid", blk_valid, 1'b1);
    repeat (3) step();
    check("t6_pulse_cnt", pulse_cnt, 66);
    check("t6_bridge", bridge, exp_bridge);
    do_ack("t6_ack");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
